mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (minimum 4, even).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port flush  input  1  abort an in-flight operation (exception path).
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo have been updated or div-by-zero is reported.
REQ-011 SHALL have port div_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b == 0.
REQ-012 SHALL have port hi  output  WIDTH  upper product half or remainder.
REQ-013 SHALL have port lo  output  WIDTH  lower product half or quotient.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIN.
REQ-015 IDLE: on start=1, SHALL latch op, |a|, |b| (signed ops) or a, b (unsigned ops), and sign flags, and enter CALC; counter loads WIDTH.
REQ-016 IDLE with start=1, DIV/DIVU, b == 0: SHALL skip CALC, enter FIN, and leave hi/lo unchanged.
REQ-017 CALC: SHALL perform one radix-2 iteration per cycle (shift-add multiply; restoring divide on magnitudes) and decrement the counter; at counter 1 SHALL enter FIN.
REQ-018 FIN: SHALL write hi/lo (except in the div-by-zero case), pulse done (and div_zero when applicable), and return to IDLE.
REQ-019 Latency: start sampled at edge N gives done high during the cycle after edge N+WIDTH+1; div-by-zero gives done during the cycle after edge N+1.
REQ-020 busy SHALL be high in CALC and FIN; low in IDLE.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 Signed multiply: the 2*WIDTH product SHALL be negated when the operand signs differ; hi = product[2W-1:W], lo = product[W-1:0].
REQ-023 Signed divide: quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend; lo = quotient, hi = remainder.
REQ-024 DIV of MIN by -1 SHALL give lo = MIN (wrapped) and hi = 0, with no flag.
REQ-025 flush=1 in CALC or FIN SHALL return the FSM to IDLE next edge, with no done and hi/lo unchanged; flush has priority over FIN's write.
REQ-026 flush=1 and start=1 together in IDLE: flush SHALL win and the start is dropped.
REQ-027 hi/lo SHALL hold their values between completed operations.
REQ-028 Operands SHALL be latched at start; a/b changes during CALC SHALL have no effect.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and clear the counter.
REQ-030 Reset mid-operation SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-031 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-032 A shared package mult_div_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state encoding.
REQ-033 The block SHALL be a single module with no sub-modules; the counter width SHALL be $clog2(WIDTH+1).
REQ-034 hi/lo SHALL connect directly to the CPU MemToReg HI/LO inputs (mfhi/mflo); done SHALL feed Control; div_zero SHALL feed the exception path alongside Overflow.

Verification (WIDTH=32)
REQ-035 MULT a=FFFFFFFD(-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB, done exactly 33 cycles after the start edge.
REQ-036 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for 33 cycles.
REQ-037 DIV a=FFFFFFF9(-7), b=00000002 -> lo=FFFFFFFD(-3), hi=FFFFFFFF(-1); DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-038 DIVU a=5, b=0 after a prior hi=1/lo=2 -> done and div_zero pulse one cycle later; hi=1, lo=2 unchanged.
REQ-039 MULT started, flush at cycle 10 -> no done, hi/lo unchanged, busy=0 next cycle; a new start is then accepted normally.
REQ-040 reset=0 at cycle 15 of a DIV -> outputs immediately 0; no done after release; start pulse during busy ignored (no second result).

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opCode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } fsmState_t;

    function automatic logic isDivOp(input opCode_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input opCode_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 multi-cycle multiply/divide unit feeding the HI/LO registers.
// Signed ops run on magnitudes; the sign fix-up is applied once, when FIN writes hi/lo.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output fsmState_t        dbgState
);

    localparam int CntW = $clog2(WIDTH + 1);

    // Handshake: start is taken only on an edge where busy is low and flush is low;
    // it is never queued. done (and div_zero) pulse for exactly one cycle, after which
    // busy is already low and hi/lo hold the new result until the next completed op.

    fsmState_t        state;
    opCode_t          opReg;
    logic             negRes;
    logic             negRem;
    logic             zeroDiv;
    logic [CntW-1:0]  cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] addend;

    logic             startSigned;
    logic             startDiv;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;
    logic [2*WIDTH-1:0] prodMag;
    logic [2*WIDTH-1:0] prodFinal;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] remFinal;

    always_comb begin
        startSigned = isSignedOp(opCode_t'(op));
        startDiv    = isDivOp(opCode_t'(op));
        absA        = (startSigned && a[WIDTH-1]) ? -a : a;
        absB        = (startSigned && b[WIDTH-1]) ? -b : b;

        // Multiply: accHi:accLo shifts right, accLo starts as the multiplier.
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, addend} : {(WIDTH + 1){1'b0}});
        // Divide: accHi is the partial remainder, accLo shifts the dividend out and quotient in.
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = divShift >= {1'b0, addend};
        divDiff  = divShift[WIDTH-1:0] - addend;

        prodMag   = {accHi, accLo};
        prodFinal = negRes ? -prodMag : prodMag;
        quoFinal  = negRes ? -accLo : accLo;
        remFinal  = negRem ? -accHi : accHi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            opReg    <= OP_MULT;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            zeroDiv  <= 1'b0;
            cnt      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            addend   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                // Aborts anything in flight and also swallows a coincident start.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opReg   <= opCode_t'(op);
                            negRes  <= startSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                            negRem  <= startSigned && a[WIDTH-1];
                            cnt     <= CntW'(WIDTH);
                            busy    <= 1'b1;
                            accHi   <= '0;
                            accLo   <= startDiv ? absA : absB;
                            addend  <= startDiv ? absB : absA;
                            zeroDiv <= startDiv && (b == '0);
                            state   <= (startDiv && (b == '0)) ? FIN : CALC;
                        end
                    end
                    CALC: begin
                        if (isDivOp(opReg)) begin
                            accHi <= divFits ? divDiff : divShift[WIDTH-1:0];
                            accLo <= {accLo[WIDTH-2:0], divFits};
                        end else begin
                            accHi <= mulSum[WIDTH:1];
                            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CntW'(1)) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        if (zeroDiv) begin
                            div_zero <= 1'b1;
                        end else if (isDivOp(opReg)) begin
                            hi <= remFinal;
                            lo <= quoFinal;
                        end else begin
                            hi <= prodFinal[2*WIDTH-1:WIDTH];
                            lo <= prodFinal[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner vectors, randomized ops against
// a plain-arithmetic reference model, flush/reset aborts and start-while-busy.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    fsmState_t    dbgState;

    int nCmp = 0;
    int nErr = 0;
    logic [W-1:0] curHi = '0;
    logic [W-1:0] curLo = '0;
    logic [W-1:0] exp_q[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo), .dbgState(dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] pHi, input logic [W-1:0] pLo,
                                  output logic [W-1:0] eHi, output logic [W-1:0] eLo, output logic dz);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        dz = 1'b0;
        eHi = pHi;
        eLo = pLo;
        case (o)
            2'b00: begin p = 64'(sx * sy); eHi = p[63:32]; eLo = p[31:0]; end
            2'b01: begin p = 64'(ux * uy); eHi = p[63:32]; eLo = p[31:0]; end
            2'b10: if (y == '0) dz = 1'b1; else begin eLo = 32'(sx / sy); eHi = 32'(sx % sy); end
            default: if (y == '0) dz = 1'b1; else begin eLo = 32'(ux / uy); eHi = 32'(ux % uy); end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 20));
        return W'($urandom);
    endfunction

    // driver + scoreboard for one complete operation
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eHi, eLo, qHi, qLo;
        logic eDz;
        int lat, busyCnt, expLat;
        model(o, x, y, curHi, curLo, eHi, eLo, eDz);
        exp_q.push_back(eHi);
        exp_q.push_back(eLo);
        expLat = eDz ? 1 : W + 1;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busyCnt++;
        end
        qHi = exp_q.pop_front();
        qLo = exp_q.pop_front();
        nCmp++; if (lat !== expLat) begin nErr++; $display("FAIL latency op=%0d a=%h b=%h: got %0d want %0d", o, x, y, lat, expLat); end
        nCmp++; if (busyCnt !== expLat) begin nErr++; $display("FAIL busy_cycles op=%0d: got %0d want %0d", o, busyCnt, expLat); end
        nCmp++; if (div_zero !== eDz) begin nErr++; $display("FAIL div_zero op=%0d a=%h b=%h: got %b want %b", o, x, y, div_zero, eDz); end
        nCmp++; if (hi !== qHi) begin nErr++; $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", o, x, y, hi, qHi); end
        nCmp++; if (lo !== qLo) begin nErr++; $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", o, x, y, lo, qLo); end
        @(negedge clk);
        nCmp++; if ({done, div_zero, busy} !== 3'b000) begin nErr++; $display("FAIL pulse_width op=%0d: done/dz/busy got %b want 000", o, {done, div_zero, busy}); end
        curHi = eHi;
        curLo = eLo;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done || div_zero) seen++;
        end
        nCmp++; if (seen !== 0) begin nErr++; $display("FAIL %s no_done: got %0d pulses want 0", tag, seen); end
        nCmp++; if ({hi, lo} !== {curHi, curLo}) begin nErr++; $display("FAIL %s hold: got %h_%h want %h_%h", tag, hi, lo, curHi, curLo); end
    endtask

    task automatic test_reset();
        logic [W-1:0] eHi, eLo;
        logic eDz;
        int lat = 0;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        nCmp++; if ({busy, done, div_zero, hi, lo} !== '0) begin nErr++; $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo); end
        nCmp++; if (dbgState !== IDLE) begin nErr++; $display("FAIL reset_fsm: got %0d want %0d", dbgState, IDLE); end
        // first start on the very first rising edge after release
        model(2'b01, 32'd3, 32'd5, curHi, curLo, eHi, eLo, eDz);
        reset = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        nCmp++; if (lat !== W + 1) begin nErr++; $display("FAIL first_start latency: got %0d want %0d", lat, W + 1); end
        nCmp++; if ({hi, lo} !== {eHi, eLo}) begin nErr++; $display("FAIL first_start result: got %h_%h want %h_%h", hi, lo, eHi, eLo); end
        curHi = eHi; curLo = eLo;
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b01, 32'd2, 32'h8000_0001);
        nCmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin nErr++; $display("FAIL setup_hi1_lo2: got %h_%h want 00000001_00000002", hi, lo); end
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        op = 2'b00; a = W'($urandom); b = W'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL flush_calc busy: got %b want 0", busy); end
        expect_quiet("flush_calc", 40);
        run_op(2'b10, 32'hFFFF_FF00, 32'd3);
        // flush landing on the FIN cycle must suppress the write
        @(negedge clk);
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);
        nCmp++; if (dbgState !== FIN) begin nErr++; $display("FAIL flush_fin setup state: got %0d want %0d", dbgState, FIN); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nCmp++; if ({busy, done} !== 2'b00) begin nErr++; $display("FAIL flush_fin: busy/done got %b want 00", {busy, done}); end
        expect_quiet("flush_fin", 40);
        // flush together with start in IDLE drops the start
        @(negedge clk);
        op = 2'b11; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL flush_start busy: got %b want 0", busy); end
        expect_quiet("flush_start", 40);
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0000_0010);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eHi, eLo;
        logic eDz;
        int doneCnt = 0;
        int dzCnt = 0;
        model(2'b01, 32'h1234_5678, 32'h0000_0100, curHi, curLo, eHi, eLo, eDz);
        @(negedge clk);
        op = 2'b01; a = 32'h1234_5678; b = 32'h0000_0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'b11; a = 32'd77; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (div_zero) dzCnt++;
        end
        nCmp++; if (doneCnt !== 1) begin nErr++; $display("FAIL busy_start done_count: got %0d want 1", doneCnt); end
        nCmp++; if (dzCnt !== 0) begin nErr++; $display("FAIL busy_start div_zero: got %0d want 0", dzCnt); end
        nCmp++; if ({hi, lo} !== {eHi, eLo}) begin nErr++; $display("FAIL busy_start result: got %h_%h want %h_%h", hi, lo, eHi, eLo); end
        curHi = eHi; curLo = eLo;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = 2'b10; a = 32'hFFFF_8000; b = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        nCmp++; if ({busy, done, div_zero, hi, lo} !== '0) begin nErr++; $display("FAIL reset_mid immediate: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo); end
        @(negedge clk);
        reset = 1'b1;
        curHi = '0; curLo = '0;
        expect_quiet("reset_mid", 50);
        run_op(2'b00, 32'd6, 32'hFFFF_FFF9);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
